// File: rtl/platform_seq_pkg.sv
// Shared state encodings and fault codes for the platform bring-up sequencer.
package platform_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD  = 3'd0,
    ST_NOC   = 3'd1,
    ST_HBM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } seq_state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_NOC     = 2'b01;
  localparam logic [1:0] FC_HBM     = 2'b10;
  localparam logic [1:0] FC_CATTRIP = 2'b11;

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchroniser with a configurable width and reset value.
module bit_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/platform_bringup_seq.sv
// Platform bring-up sequencer: releases NoC, HBM and app resets in order with bounded waits.
// state | meaning: HOLD all resets held | NOC wait noc init | HBM wait hbm cal | RUN app live | FAULT all held, wait restart
module platform_bringup_seq
  import platform_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES    = 256,
  parameter int         TIMEOUT_CYCLES = 1048576,
  parameter logic [2:0] TEMP_THROTTLE  = 3'd5,
  parameter int         CNT_W          = 32
) (
  input  logic         sys_clk,
  input  logic         sys_reset_n,
  input  logic         hbm_cattrip_i,
  input  logic [2:0]   hbm_temp_i,
  input  logic         pcie_reset_n,
  input  logic         noc_init_done,
  input  logic         hbm_cal_done,
  input  logic         restart,
  output logic         noc_rst_n,
  output logic         hbm_rst_n,
  output logic         app_rst_n,
  output logic         throttle,
  output logic         fault,
  output logic [1:0]   fault_code,
  output logic [STATE_W-1:0] seq_state
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       TEMP_CLEAR   = TEMP_THROTTLE - 3'd1;

  logic       cattrip_sync;
  logic       pcie_sync;
  logic [2:0] temp_sync;

  bit_sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_cattrip (
    .clk(sys_clk), .reset_n(sys_reset_n), .d(hbm_cattrip_i), .q(cattrip_sync)
  );

  bit_sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_pcie (
    .clk(sys_clk), .reset_n(sys_reset_n), .d(pcie_reset_n), .q(pcie_sync)
  );

  bit_sync_2ff #(.WIDTH(3), .RESET_VAL(3'd0)) u_sync_temp (
    .clk(sys_clk), .reset_n(sys_reset_n), .d(hbm_temp_i), .q(temp_sync)
  );

  // Temperature code is only trusted once it has been stable for two synchronised samples.
  logic [2:0] temp_prev;
  logic [2:0] temp_acc;
  logic [2:0] temp_next;

  always_comb begin
    temp_next = temp_acc;
    if (temp_sync == temp_prev) temp_next = temp_sync;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      temp_prev <= 3'd0;
      temp_acc  <= 3'd0;
      throttle  <= 1'b0;
    end else begin
      temp_prev <= temp_sync;
      temp_acc  <= temp_next;
      if (temp_next >= TEMP_THROTTLE) throttle <= 1'b1;
      else if (temp_next < TEMP_CLEAR) throttle <= 1'b0;
    end
  end

  seq_state_t       state_q, state_next;
  logic [1:0]       code_next;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    state_next = state_q;
    code_next  = fault_code;
    unique case (state_q)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) state_next = ST_NOC;
      end
      ST_NOC: begin
        if (noc_init_done) state_next = ST_HBM;
        else if (cnt == TIMEOUT_LAST) begin
          state_next = ST_FAULT;
          code_next  = FC_NOC;
        end
      end
      ST_HBM: begin
        if (hbm_cal_done) state_next = ST_RUN;
        else if (cnt == TIMEOUT_LAST) begin
          state_next = ST_FAULT;
          code_next  = FC_HBM;
        end
      end
      ST_RUN: begin
        if (!noc_init_done) begin
          state_next = ST_FAULT;
          code_next  = FC_NOC;
        end else if (!hbm_cal_done) begin
          state_next = ST_FAULT;
          code_next  = FC_HBM;
        end
      end
      ST_FAULT: begin
        if (restart && !cattrip_sync) begin
          state_next = ST_HOLD;
          code_next  = FC_NONE;
        end
      end
      default: begin
        state_next = ST_HOLD;
        code_next  = FC_NONE;
      end
    endcase
    // Over-temperature trip beats any done or timeout decided above.
    if (cattrip_sync && state_q != ST_FAULT) begin
      state_next = ST_FAULT;
      code_next  = FC_CATTRIP;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q    <= ST_HOLD;
      cnt        <= '0;
      fault_code <= FC_NONE;
      noc_rst_n  <= 1'b0;
      hbm_rst_n  <= 1'b0;
      app_rst_n  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_next;
      fault_code <= code_next;
      if (state_next != state_q) cnt <= '0;
      else if (cnt != '1) cnt <= cnt + CNT_W'(1);
      noc_rst_n  <= (state_next == ST_NOC) || (state_next == ST_HBM) || (state_next == ST_RUN);
      hbm_rst_n  <= (state_next == ST_HBM) || (state_next == ST_RUN);
      app_rst_n  <= (state_next == ST_RUN) && pcie_sync;
      fault      <= (state_next == ST_FAULT);
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_platform_bringup_seq.sv
// Directed self-checking bench for platform_bringup_seq with HOLD_CYCLES=8, TIMEOUT_CYCLES=16.
module tb_platform_bringup_seq;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n;
  logic       hbm_cattrip_i;
  logic [2:0] hbm_temp_i;
  logic       pcie_reset_n;
  logic       noc_init_done;
  logic       hbm_cal_done;
  logic       restart;
  logic       noc_rst_n;
  logic       hbm_rst_n;
  logic       app_rst_n;
  logic       throttle;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] seq_state;

  int checks   = 0;
  int failures = 0;

  platform_bringup_seq #(
    .HOLD_CYCLES(8), .TIMEOUT_CYCLES(16), .TEMP_THROTTLE(3'd5), .CNT_W(32)
  ) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .hbm_cattrip_i(hbm_cattrip_i),
    .hbm_temp_i(hbm_temp_i), .pcie_reset_n(pcie_reset_n), .noc_init_done(noc_init_done),
    .hbm_cal_done(hbm_cal_done), .restart(restart), .noc_rst_n(noc_rst_n),
    .hbm_rst_n(hbm_rst_n), .app_rst_n(app_rst_n), .throttle(throttle), .fault(fault),
    .fault_code(fault_code), .seq_state(seq_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    sys_reset_n = 1'b0; hbm_cattrip_i = 1'b0; hbm_temp_i = 3'd0; pcie_reset_n = 1'b0;
    noc_init_done = 1'b0; hbm_cal_done = 1'b0; restart = 1'b0;
    step(3);
    chk("rst_state", 8'(seq_state), 8'd0);
    chk("rst_noc", 8'(noc_rst_n), 8'd0);
    chk("rst_hbm", 8'(hbm_rst_n), 8'd0);
    chk("rst_app", 8'(app_rst_n), 8'd0);
    chk("rst_throttle", 8'(throttle), 8'd0);
    chk("rst_fault", 8'(fault), 8'd0);
    chk("rst_code", 8'(fault_code), 8'd0);

    // Nominal bring-up: noc done in cycle 12, hbm done in cycle 20.
    sys_reset_n = 1'b1;
    step(7);
    chk("hold_c7_state", 8'(seq_state), 8'd0);
    chk("hold_c7_noc", 8'(noc_rst_n), 8'd0);
    step(1);
    chk("noc_c8_state", 8'(seq_state), 8'd1);
    chk("noc_c8_noc", 8'(noc_rst_n), 8'd1);
    chk("noc_c8_hbm", 8'(hbm_rst_n), 8'd0);
    step(4);
    chk("noc_c12_state", 8'(seq_state), 8'd1);
    noc_init_done = 1'b1;
    step(1);
    chk("hbm_c13_state", 8'(seq_state), 8'd2);
    chk("hbm_c13_hbm", 8'(hbm_rst_n), 8'd1);
    chk("hbm_c13_app", 8'(app_rst_n), 8'd0);
    step(7);
    chk("hbm_c20_state", 8'(seq_state), 8'd2);
    hbm_cal_done = 1'b1;
    step(1);
    chk("run_c21_state", 8'(seq_state), 8'd3);
    chk("run_c21_app", 8'(app_rst_n), 8'd0);
    chk("run_c21_fault", 8'(fault), 8'd0);
    pcie_reset_n = 1'b1;
    step(2);
    chk("app_lat2", 8'(app_rst_n), 8'd0);
    step(1);
    chk("app_lat3", 8'(app_rst_n), 8'd1);

    // Synchronous reset while in RUN.
    sys_reset_n = 1'b0; noc_init_done = 1'b0; hbm_cal_done = 1'b0;
    step(1);
    chk("midrst_state", 8'(seq_state), 8'd0);
    chk("midrst_noc", 8'(noc_rst_n), 8'd0);
    chk("midrst_hbm", 8'(hbm_rst_n), 8'd0);
    chk("midrst_app", 8'(app_rst_n), 8'd0);
    sys_reset_n = 1'b1;

    // NoC timeout, with a stray restart pulse in NOC.
    step(8);
    chk("to_noc_entry", 8'(seq_state), 8'd1);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("restart_ignored", 8'(seq_state), 8'd1);
    step(14);
    chk("to_noc_c15", 8'(seq_state), 8'd1);
    step(1);
    chk("to_noc_state", 8'(seq_state), 8'd4);
    chk("to_noc_fault", 8'(fault), 8'd1);
    chk("to_noc_code", 8'(fault_code), 8'd1);
    chk("to_noc_nocrst", 8'(noc_rst_n), 8'd0);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("recover_state", 8'(seq_state), 8'd0);
    chk("recover_code", 8'(fault_code), 8'd0);
    chk("recover_fault", 8'(fault), 8'd0);

    // hbm_cal_done arrives in the timeout cycle: done wins.
    noc_init_done = 1'b1;
    step(8);
    chk("race_noc", 8'(seq_state), 8'd1);
    step(1);
    chk("race_hbm", 8'(seq_state), 8'd2);
    step(15);
    chk("race_pre_to", 8'(seq_state), 8'd2);
    hbm_cal_done = 1'b1;
    step(1);
    chk("race_state", 8'(seq_state), 8'd3);
    chk("race_fault", 8'(fault), 8'd0);
    chk("race_code", 8'(fault_code), 8'd0);

    // Cattrip during HBM, restart blocked until it clears.
    sys_reset_n = 1'b0; hbm_cal_done = 1'b0;
    step(1);
    sys_reset_n = 1'b1;
    step(9);
    chk("ct_hbm", 8'(seq_state), 8'd2);
    hbm_cattrip_i = 1'b1;
    step(2);
    chk("ct_lat2_fault", 8'(fault), 8'd0);
    step(1);
    chk("ct_lat3_fault", 8'(fault), 8'd1);
    chk("ct_state", 8'(seq_state), 8'd4);
    chk("ct_code", 8'(fault_code), 8'd3);
    chk("ct_hbmrst", 8'(hbm_rst_n), 8'd0);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("ct_restart_held", 8'(seq_state), 8'd4);
    hbm_cattrip_i = 1'b0;
    step(2);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("ct_recover_state", 8'(seq_state), 8'd0);
    chk("ct_recover_code", 8'(fault_code), 8'd0);

    // Throttle hysteresis 4 -> 5 -> 4 -> 3, then a 1-cycle glitch to 7.
    hbm_temp_i = 3'd4;
    step(6);
    chk("thr_t4", 8'(throttle), 8'd0);
    hbm_temp_i = 3'd5;
    step(3);
    chk("thr_t5_lat3", 8'(throttle), 8'd0);
    step(1);
    chk("thr_t5_lat4", 8'(throttle), 8'd1);
    step(2);
    hbm_temp_i = 3'd4;
    step(6);
    chk("thr_hold4", 8'(throttle), 8'd1);
    hbm_temp_i = 3'd3;
    step(3);
    chk("thr_t3_lat3", 8'(throttle), 8'd1);
    step(1);
    chk("thr_t3_lat4", 8'(throttle), 8'd0);
    step(2);
    hbm_temp_i = 3'd7;
    step(1);
    hbm_temp_i = 3'd3;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("thr_glitch", 8'(throttle), 8'd0);
    end
    // Meanwhile hbm_cal_done stayed low, so the HBM wait timed out.
    chk("to_hbm_state", 8'(seq_state), 8'd4);
    chk("to_hbm_code", 8'(fault_code), 8'd2);
    chk("to_hbm_fault", 8'(fault), 8'd1);

    // Loss of both dones in RUN: NoC loss reported.
    hbm_cal_done = 1'b1; restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("loss_hold", 8'(seq_state), 8'd0);
    step(10);
    chk("loss_run", 8'(seq_state), 8'd3);
    noc_init_done = 1'b0; hbm_cal_done = 1'b0;
    step(1);
    chk("loss_both_state", 8'(seq_state), 8'd4);
    chk("loss_both_code", 8'(fault_code), 8'd1);

    // Loss of hbm_cal_done alone in RUN.
    noc_init_done = 1'b1; hbm_cal_done = 1'b1; restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(10);
    chk("loss2_run", 8'(seq_state), 8'd3);
    hbm_cal_done = 1'b0;
    step(1);
    chk("loss_hbm_state", 8'(seq_state), 8'd4);
    chk("loss_hbm_code", 8'(fault_code), 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
